// File: rtl/int_arbiter.sv
// int_arbiter: edge-detecting, fixed-priority peripheral interrupt arbiter with claim/complete handshake
//   clk           core clock, all state on posedge
//   rst           synchronous active-high reset
//   irq_src       level request lines, synchronous to clk
//   en_wdata      enable mask write data
//   en_we         load en_wdata into the enable mask
//   en_q          current enable mask
//   pending_q     latched pending bits
//   int_code      presented code (index+1), 0 when none
//   int_ack       core claimed the presented interrupt
//   int_complete  handler finished
//   complete_code code being completed
//   busy          an interrupt is in service
module int_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int CODE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               en_we,
    output logic [NUM_SRC-1:0] en_q,
    output logic [NUM_SRC-1:0] pending_q,
    output logic [CODE_W-1:0]  int_code,
    input  logic               int_ack,
    input  logic               int_complete,
    input  logic [CODE_W-1:0]  complete_code,
    output logic               busy
);
    localparam int IDX_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
    state_t state_q, state_d;
    logic [NUM_SRC-1:0] src_q, rise, eligible, clr, pending_d;
    logic [IDX_W-1:0] cur_q, cur_d, winner;
    logic [CODE_W-1:0] code_d, cur_code;
    logic busy_d;
    assign rise      = irq_src & ~src_q;
    assign eligible  = pending_q & en_q;
    assign cur_code  = CODE_W'(cur_q) + CODE_W'(1);
    // a new edge wins over the claim clear of the same source
    assign pending_d = (pending_q & ~clr) | (rise & en_q);
    // scan high to low so the lowest eligible index is left standing
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) winner = IDX_W'(i);
    end
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        code_d  = int_code;
        busy_d  = busy;
        clr     = '0;
        case (state_q)
            IDLE: if (|eligible) begin
                cur_d   = winner;
                code_d  = CODE_W'(winner) + CODE_W'(1);
                state_d = PRESENT;
            end
            PRESENT: if (int_ack) begin
                clr[cur_q] = 1'b1;
                code_d     = '0;
                busy_d     = 1'b1;
                state_d    = SERVICE;
            end else if (!en_q[cur_q]) begin
                // source masked while presented: withdraw, keep it pending
                code_d  = '0;
                state_d = IDLE;
            end
            SERVICE: if (int_complete && complete_code == cur_code) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            en_q      <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            cur_q     <= '0;
            int_code  <= '0;
            busy      <= 1'b0;
        end else begin
            src_q     <= irq_src;
            en_q      <= en_we ? en_wdata : en_q;
            pending_q <= pending_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            int_code  <= code_d;
            busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed self-checking bench for int_arbiter
module tb_int_arbiter;
    logic       clk, rst, en_we, int_ack, int_complete, busy;
    logic [7:0] irq_src, en_wdata, en_q, pending_q;
    logic [3:0] int_code, complete_code;
    int passed = 0;
    int total  = 0;

    int_arbiter #(.NUM_SRC(8), .CODE_W(4)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .en_wdata(en_wdata), .en_we(en_we),
        .en_q(en_q), .pending_q(pending_q), .int_code(int_code), .int_ack(int_ack),
        .int_complete(int_complete), .complete_code(complete_code), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [7:0] m);
        en_wdata = m;
        en_we = 1;
        tick();
        en_we = 0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_src = m;
        tick();
        irq_src = 0;
    endtask

    task automatic ack();
        int_ack = 1;
        tick();
        int_ack = 0;
    endtask

    task automatic complete(input logic [3:0] c);
        int_complete = 1;
        complete_code = c;
        tick();
        int_complete = 0;
        complete_code = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        irq_src = 8'hFF;
        tick();
        tick();
        total++; if (int_code !== 4'd0) $display("FAIL reset_code: got %0d expected 0", int_code); else passed++;
        total++; if (pending_q !== 8'h00) $display("FAIL reset_pending: got %h expected 00", pending_q); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (en_q !== 8'h00) $display("FAIL reset_en: got %h expected 00", en_q); else passed++;
        rst = 0;
        irq_src = 0;
        tick();
    endtask

    task automatic test_basic();
        set_en(8'hFF);
        total++; if (en_q !== 8'hFF) $display("FAIL basic_en: got %h expected ff", en_q); else passed++;
        pulse_irq(8'h20);
        total++; if (pending_q !== 8'h20) $display("FAIL basic_pending: got %h expected 20", pending_q); else passed++;
        total++; if (int_code !== 4'd0) $display("FAIL basic_code_n1: got %0d expected 0", int_code); else passed++;
        tick();
        total++; if (int_code !== 4'd6) $display("FAIL basic_code_n2: got %0d expected 6", int_code); else passed++;
        ack();
        total++; if (int_code !== 4'd0) $display("FAIL basic_ack_code: got %0d expected 0", int_code); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_ack_busy: got %b expected 1", busy); else passed++;
        total++; if (pending_q !== 8'h00) $display("FAIL basic_ack_pending: got %h expected 00", pending_q); else passed++;
        complete(4'd6);
        total++; if (busy !== 1'b0) $display("FAIL basic_complete_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_priority();
        pulse_irq(8'h44);
        total++; if (pending_q !== 8'h44) $display("FAIL prio_pending: got %h expected 44", pending_q); else passed++;
        tick();
        total++; if (int_code !== 4'd3) $display("FAIL prio_first: got %0d expected 3", int_code); else passed++;
        ack();
        total++; if (pending_q !== 8'h40) $display("FAIL prio_ack_pending: got %h expected 40", pending_q); else passed++;
        complete(4'd3);
        total++; if (busy !== 1'b0) $display("FAIL prio_busy: got %b expected 0", busy); else passed++;
        tick();
        total++; if (int_code !== 4'd7) $display("FAIL prio_second: got %0d expected 7", int_code); else passed++;
        ack();
        complete(4'd7);
        total++; if (busy !== 1'b0) $display("FAIL prio_second_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_bad_complete();
        pulse_irq(8'h04);
        tick();
        ack();
        irq_src = 8'h04;
        complete(4'd5);
        irq_src = 0;
        total++; if (busy !== 1'b1) $display("FAIL badc_busy: got %b expected 1", busy); else passed++;
        total++; if (pending_q !== 8'h04) $display("FAIL badc_repend: got %h expected 04", pending_q); else passed++;
        total++; if (int_code !== 4'd0) $display("FAIL badc_code: got %0d expected 0", int_code); else passed++;
        ack();
        total++; if (busy !== 1'b1 || pending_q !== 8'h04) $display("FAIL badc_stray_ack: got busy=%b pending=%h expected busy=1 pending=04", busy, pending_q); else passed++;
        complete(4'd3);
        total++; if (busy !== 1'b0) $display("FAIL badc_done: got %b expected 0", busy); else passed++;
        tick();
        total++; if (int_code !== 4'd3) $display("FAIL badc_represent: got %0d expected 3", int_code); else passed++;
        ack();
        complete(4'd3);
    endtask

    task automatic test_masked();
        set_en(8'h01);
        irq_src = 8'h02;
        tick();
        total++; if (pending_q !== 8'h00) $display("FAIL mask_pending: got %h expected 00", pending_q); else passed++;
        tick();
        tick();
        tick();
        total++; if (int_code !== 4'd0) $display("FAIL mask_code: got %0d expected 0", int_code); else passed++;
        set_en(8'hFF);
        tick();
        tick();
        total++; if (int_code !== 4'd0 || pending_q !== 8'h00) $display("FAIL mask_level: got code=%0d pending=%h expected code=0 pending=00", int_code, pending_q); else passed++;
        irq_src = 0;
        tick();
    endtask

    task automatic test_no_preempt();
        pulse_irq(8'h80);
        tick();
        total++; if (int_code !== 4'd8) $display("FAIL nopre_first: got %0d expected 8", int_code); else passed++;
        pulse_irq(8'h01);
        tick();
        total++; if (int_code !== 4'd8) $display("FAIL nopre_hold: got %0d expected 8", int_code); else passed++;
        total++; if (pending_q !== 8'h81) $display("FAIL nopre_pending: got %h expected 81", pending_q); else passed++;
        ack();
        complete(4'd8);
        tick();
        total++; if (int_code !== 4'd1) $display("FAIL nopre_next: got %0d expected 1", int_code); else passed++;
        ack();
        complete(4'd1);
    endtask

    task automatic test_ack_vs_withdraw();
        pulse_irq(8'h02);
        tick();
        total++; if (int_code !== 4'd2) $display("FAIL ackwd_present: got %0d expected 2", int_code); else passed++;
        set_en(8'hFD);
        int_ack = 1;
        tick();
        int_ack = 0;
        total++; if (busy !== 1'b1 || int_code !== 4'd0 || pending_q !== 8'h00) $display("FAIL ackwd_ack: got busy=%b code=%0d pending=%h expected busy=1 code=0 pending=00", busy, int_code, pending_q); else passed++;
        complete(4'd2);
        total++; if (busy !== 1'b0) $display("FAIL ackwd_done: got %b expected 0", busy); else passed++;
        set_en(8'hFF);
    endtask

    task automatic test_withdraw();
        pulse_irq(8'h08);
        tick();
        total++; if (int_code !== 4'd4) $display("FAIL wd_present: got %0d expected 4", int_code); else passed++;
        set_en(8'hF7);
        total++; if (int_code !== 4'd4) $display("FAIL wd_still: got %0d expected 4", int_code); else passed++;
        tick();
        total++; if (int_code !== 4'd0) $display("FAIL wd_code: got %0d expected 0", int_code); else passed++;
        total++; if (pending_q !== 8'h08 || busy !== 1'b0) $display("FAIL wd_kept: got pending=%h busy=%b expected pending=08 busy=0", pending_q, busy); else passed++;
        tick();
        total++; if (int_code !== 4'd0) $display("FAIL wd_idle: got %0d expected 0", int_code); else passed++;
        set_en(8'hFF);
        total++; if (int_code !== 4'd0) $display("FAIL wd_reen_n1: got %0d expected 0", int_code); else passed++;
        tick();
        total++; if (int_code !== 4'd4) $display("FAIL wd_reen_n2: got %0d expected 4", int_code); else passed++;
        ack();
        total++; if (busy !== 1'b1) $display("FAIL wd_service: got %b expected 1", busy); else passed++;
        rst = 1;
        tick();
        rst = 0;
        total++; if (busy !== 1'b0 || int_code !== 4'd0) $display("FAIL wd_rst: got busy=%b code=%0d expected busy=0 code=0", busy, int_code); else passed++;
        total++; if (en_q !== 8'h00 || pending_q !== 8'h00) $display("FAIL wd_rst_regs: got en=%h pending=%h expected en=00 pending=00", en_q, pending_q); else passed++;
    endtask

    initial begin
        rst = 1;
        irq_src = 0;
        en_wdata = 0;
        en_we = 0;
        int_ack = 0;
        int_complete = 0;
        complete_code = 0;
        test_reset();
        test_basic();
        test_priority();
        test_bad_complete();
        test_masked();
        test_no_preempt();
        test_ack_vs_withdraw();
        test_withdraw();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
